tag_match_pipe: RTL
===================

Name: tag_match_pipe

Overview:
- Parametrised, pipelined successor to the combinational 16-entry tag matcher in tag_sort.
- Owns a 2^TAG_W-bit tag occupancy bitmap internally instead of taking the mask as an input.
- Accepts insert, remove, search and search-and-pop operations through a valid/ready handshake.
- Returns the smallest occupied tag >= the query tag with a fixed 2-cycle latency; it is the lookup engine for the tag sorter scheduler.

Parameters:
- TAG_W, 4, tag width; bitmap has N = 2^TAG_W entries.
- SEG_W, 2, log2 of segment size for the two-level search; must satisfy 1 <= SEG_W < TAG_W.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- op_valid  in  1  operation request valid.
- op_ready  out  1  block can accept an operation this cycle.
- op_code  in  2  00 SEARCH, 01 INSERT, 10 REMOVE, 11 POP (search then clear the hit).
- op_tag  in  TAG_W  query/insert/remove tag.
- res_valid  out  1  single-cycle result pulse; no backpressure.
- res_tag  out  TAG_W  matched tag; 0 when res_found=0.
- res_found  out  1  SEARCH/POP: a match exists. INSERT/REMOVE: the addressed bit was already set before the op.
- res_wrap  out  1  match came from wrap-around; tied 0 without the macro.
- occ  out  N  current bitmap (registered).
- count  out  TAG_W+1  number of set bits in occ.

Behaviour:
- Reset: occ=0, count=0, res_valid=0, res_tag=0, res_found=0, res_wrap=0, pipeline emptied, op_ready=0 while rst=1. op_ready=1 in the first cycle after rst falls.
- Reset mid-operation: in-flight ops are discarded without a result; a POP in flight does not clear its bit.
- Accept: an op is accepted on a rising edge where op_valid & op_ready.
- Latency: res_valid pulses exactly 2 cycles after the accept edge for every op code. Ops complete in acceptance order.
- Throughput: one op per cycle for SEARCH, INSERT and REMOVE.
- POP throughput: op_ready=0 in the cycle after a POP is accepted, so a POP occupies 2 issue slots.
- INSERT/REMOVE bitmap update: occ[op_tag] is updated at the accept edge. count is updated at the same edge by +1 or -1 only if the bit actually changes.
- Duplicate INSERT and REMOVE of an absent tag leave occ and count unchanged; res_found reports the prior bit value.
- Search snapshot: taken from occ before the accept edge. It includes every previously accepted op, including an INSERT accepted the preceding cycle.
- Stage 1 (edge 1): masked = occ & ~((1<<op_tag)-1). Register seg_any[k] = OR of masked segment k (N>>SEG_W segments) plus the masked vector.
- Stage 2 (edge 2): the lowest k with seg_any[k]=1 is selected, then the lowest set bit within that segment. res_tag = {k, bit}, res_found=1.
- No match: all seg_any=0 gives res_found=0 and res_tag=0.
- POP: if found, occ[res_tag] is cleared and count decremented at stage-2 edge. The op_ready stall guarantees no search observes the stale bit.
- Boundaries: op_tag=0 searches the whole bitmap. op_tag=N-1 checks only bit N-1.
- Full bitmap: count=N, and INSERT returns res_found=1. Empty bitmap: all searches return not found.

Optional Feature:
- Macro: TAG_MATCH_WRAP_EN.
- Defined: when no set bit >= op_tag exists but occ is nonzero, the lowest set tag overall is returned with res_found=1 and res_wrap=1. This requires a parallel unmasked segment search in stage 1. POP also clears the wrapped hit.
- Not defined: no wrap logic is built; res_wrap is a constant 0.

Decomposition:
- Package tag_match_pkg holds: op-code constants (OP_SEARCH, OP_INSERT, OP_REMOVE, OP_POP), the 2-bit op-code typedef, and a segment-count function N>>SEG_W.
- One sub-module: ffs_lsb, a parametrised width-W find-first-set (lowest set bit index plus any flag). It is instantiated for segment select and for in-segment select.

Test Plan (TAG_W=4, SEG_W=2):
- Reset, then SEARCH tag 5 on empty -> res_valid 2 cycles after accept, found=0, tag=0, count=0.
- INSERT 3 twice -> found=0 then found=1, occ=16'h0008, count=1.
- occ=16'h0008, SEARCH 0..15 back-to-back one per cycle:
  - d=0..3 -> tag 3, found=1.
  - d=4..15 -> found=0 without the macro; found=1, tag=3, wrap=1 with TAG_MATCH_WRAP_EN.
- INSERT 2, 9, 14; SEARCH 10 -> 14; SEARCH 15 -> not found; SEARCH 4 -> 9 (cross-segment); REMOVE 9 -> found=1, count=3.
- occ={2,9}, POP 0 -> tag 2, op_ready=0 for one cycle; next SEARCH 0 -> 9. INSERT 7 followed next cycle by SEARCH 6 -> 7.
- Assert rst one cycle after a POP is accepted -> no res_valid, occ=0, count=0, op_ready=1 the cycle after rst falls.

Source files
------------

// File: rtl/tag_match_pkg.sv
// rtl/tag_match_pkg.sv - op codes and sizing helper shared by tag_match_pipe
package tag_match_pkg;

  typedef logic [1:0] op_code_t;

  localparam op_code_t OP_SEARCH = 2'b00;
  localparam op_code_t OP_INSERT = 2'b01;
  localparam op_code_t OP_REMOVE = 2'b10;
  localparam op_code_t OP_POP    = 2'b11;

  function automatic int seg_count(input int tag_w, input int seg_w);
    return (1 << tag_w) >> seg_w;
  endfunction

endpackage

// File: rtl/ffs_lsb.sv
// rtl/ffs_lsb.sv - find-first-set: index of the lowest set bit plus an any-set flag
module ffs_lsb #(
  parameter int W = 4,
  localparam int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
    any = |vec;
  end

endmodule

// File: rtl/tag_match_pipe.sv
// rtl/tag_match_pipe.sv - two-stage smallest-tag>=query search over an internal occupancy bitmap
// Define TAG_MATCH_WRAP_EN to return the lowest occupied tag when nothing >= the query exists.
module tag_match_pipe
  import tag_match_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int SEG_W = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    op_valid,
  output logic                    op_ready,
  input  logic [1:0]              op_code,
  input  logic [TAG_W-1:0]        op_tag,
  output logic                    res_valid,
  output logic [TAG_W-1:0]        res_tag,
  output logic                    res_found,
  output logic                    res_wrap,
  output logic [(1<<TAG_W)-1:0]   occ,
  output logic [TAG_W:0]          count
);

  localparam int N    = 1 << TAG_W;
  localparam int NSEG = seg_count(TAG_W, SEG_W);
  localparam int SEG  = 1 << SEG_W;
  localparam int KW   = TAG_W - SEG_W;

  localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};
  localparam logic [TAG_W:0] ONE_C = {{TAG_W{1'b0}}, 1'b1};

  logic              accept;
  logic              pop_stall;
  logic [N-1:0]      lower_mask;
  logic [N-1:0]      masked;
  logic [NSEG-1:0]   seg_any;

  logic              s1_valid;
  op_code_t          s1_op;
  logic [TAG_W-1:0]  s1_tag;
  logic              s1_prior;
  logic [N-1:0]      s1_masked;
  logic [NSEG-1:0]   s1_seg_any;

  logic [NSEG-1:0]   sel_seg;
  logic [N-1:0]      sel_vec;
  logic [KW-1:0]     sel_k;
  logic              seg_hit;
  logic [SEG-1:0]    seg_bits;
  logic [SEG_W-1:0]  sel_b;
  logic              bit_hit;
  logic              st2_found;
  logic [TAG_W-1:0]  st2_tag;

  logic [N-1:0]      occ_next;
  logic [TAG_W:0]    count_next;

  // A POP holds off the next issue slot so its clear lands before the next snapshot.
  assign op_ready = ~rst & ~pop_stall;
  assign accept   = op_valid & op_ready;

  assign lower_mask = (ONE_N << op_tag) - ONE_N;
  assign masked     = occ & ~lower_mask;

  always_comb begin
    seg_any = '0;
    for (int k = 0; k < NSEG; k++) begin
      seg_any[k] = |masked[k*SEG +: SEG];
    end
  end

`ifdef TAG_MATCH_WRAP_EN
  logic [NSEG-1:0] useg_any;
  logic [NSEG-1:0] s1_useg_any;
  logic [N-1:0]    s1_occ;
  logic            st2_wrap;

  always_comb begin
    useg_any = '0;
    for (int k = 0; k < NSEG; k++) begin
      useg_any[k] = |occ[k*SEG +: SEG];
    end
  end

  always_ff @(posedge clk) begin
    s1_useg_any <= useg_any;
    s1_occ      <= occ;
  end

  assign st2_wrap = ~(|s1_seg_any) & (|s1_useg_any);
  assign sel_seg  = st2_wrap ? s1_useg_any : s1_seg_any;
  assign sel_vec  = st2_wrap ? s1_occ : s1_masked;

  always_ff @(posedge clk) begin
    if (rst) begin
      res_wrap <= 1'b0;
    end else if (s1_valid) begin
      res_wrap <= st2_wrap & ((s1_op == OP_SEARCH) | (s1_op == OP_POP));
    end
  end
`else
  assign sel_seg  = s1_seg_any;
  assign sel_vec  = s1_masked;
  assign res_wrap = 1'b0;
`endif

  ffs_lsb #(.W(NSEG)) u_seg_sel (
    .vec (sel_seg),
    .idx (sel_k),
    .any (seg_hit)
  );

  always_comb begin
    seg_bits = '0;
    for (int k = 0; k < NSEG; k++) begin
      if (sel_k == KW'(k)) seg_bits = sel_vec[k*SEG +: SEG];
    end
  end

  ffs_lsb #(.W(SEG)) u_bit_sel (
    .vec (seg_bits),
    .idx (sel_b),
    .any (bit_hit)
  );

  assign st2_found = seg_hit & bit_hit;
  assign st2_tag   = {sel_k, sel_b};

  always_comb begin
    occ_next   = occ;
    count_next = count;
    if (accept && (op_code == OP_INSERT) && !occ[op_tag]) begin
      occ_next[op_tag] = 1'b1;
      count_next       = count + ONE_C;
    end else if (accept && (op_code == OP_REMOVE) && occ[op_tag]) begin
      occ_next[op_tag] = 1'b0;
      count_next       = count - ONE_C;
    end
    if (s1_valid && (s1_op == OP_POP) && st2_found) begin
      occ_next[st2_tag] = 1'b0;
      count_next        = count_next - ONE_C;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ        <= '0;
      count      <= '0;
      pop_stall  <= 1'b0;
      s1_valid   <= 1'b0;
      s1_op      <= OP_SEARCH;
      s1_tag     <= '0;
      s1_prior   <= 1'b0;
      s1_masked  <= '0;
      s1_seg_any <= '0;
      res_valid  <= 1'b0;
      res_tag    <= '0;
      res_found  <= 1'b0;
    end else begin
      occ        <= occ_next;
      count      <= count_next;
      pop_stall  <= accept & (op_code == OP_POP);
      s1_valid   <= accept;
      s1_op      <= op_code;
      s1_tag     <= op_tag;
      s1_prior   <= occ[op_tag];
      s1_masked  <= masked;
      s1_seg_any <= seg_any;
      res_valid  <= s1_valid;
      if (s1_valid) begin
        if ((s1_op == OP_INSERT) || (s1_op == OP_REMOVE)) begin
          res_found <= s1_prior;
          res_tag   <= s1_prior ? s1_tag : '0;
        end else begin
          res_found <= st2_found;
          res_tag   <= st2_found ? st2_tag : '0;
        end
      end
    end
  end

endmodule
